// File: rtl/joypad_pkg.sv
// joypad_pkg
// Shared constants for the joypad front end.
//   BTN_*        : bit positions of each button within the 8-bit button vectors.
//   JOYP_SEL_*   : bit positions within button_sel; a 0 on that bit enables the group.
package joypad_pkg;

    localparam int BTN_RIGHT  = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_UP     = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_A      = 4;
    localparam int BTN_B      = 5;
    localparam int BTN_SELECT = 6;
    localparam int BTN_START  = 7;

    localparam int NUM_BUTTONS = 8;

    localparam int JOYP_SEL_DIR = 0;
    localparam int JOYP_SEL_ACT = 1;

endpackage

// File: rtl/joypad_debouncer_debounce_bit.sv
// debounce_bit
// Two-flop synchroniser followed by a saturating-on-match debounce counter for
// one push-button line. The stable state flips only after the synchronised
// input has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high
//   raw    : asynchronous button input, 1 = pressed
//   state  : debounced button state, 1 = pressed
module debounce_bit #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd40000,
    parameter int          CNT_WIDTH       = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic state
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 16'd1);

    logic                 sync1;
    logic                 sync2;
    logic [CNT_WIDTH-1:0] cnt;

    // Synchroniser: back-to-back flops, nothing in between.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: any agreement with the current state restarts the count, so a
    // bounce shorter than the window can never flip the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            state <= 1'b0;
        end else if (sync2 == state) begin
            cnt   <= '0;
        end else if (cnt == CNT_MAX) begin
            state <= sync2;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/joypad_debouncer.sv
// joypad_debouncer
// Front end of the joypad path: synchronises and debounces the eight raw
// buttons, presents the active-low nibble selected by button_sel and pulses
// joy_irq for one cycle on any high-to-low transition of that nibble.
// Ports:
//   clock       : system clock
//   reset       : synchronous, active-high
//   btn_raw     : raw buttons, 1 = pressed (Right, Left, Up, Down, A, B, Select, Start)
//   button_sel  : group select, bit 0 low = directions, bit 1 low = actions
//   button_data : active-low nibble (Down/Start, Up/Select, Left/B, Right/A)
//   btn_state   : debounced buttons, 1 = pressed
//   joy_irq     : one-cycle pulse on any falling edge of button_data
module joypad_debouncer
    import joypad_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd40000,
    parameter int          CNT_WIDTH       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] btn_raw,
    input  logic [1:0] button_sel,
    output logic [3:0] button_data,
    output logic [7:0] btn_state,
    output logic       joy_irq
);

    logic [3:0] prev_data;

    // Both groups may be enabled at once; the nibble is then their OR, inverted.
    function automatic logic [3:0] sel_nibble(input logic [7:0] state,
                                              input logic [1:0] sel);
        logic [3:0] dirs;
        logic [3:0] acts;
        dirs = state[BTN_DOWN:BTN_RIGHT];
        acts = state[BTN_START:BTN_A];
        return ~((dirs & {4{~sel[JOYP_SEL_DIR]}}) |
                 (acts & {4{~sel[JOYP_SEL_ACT]}}));
    endfunction

    // Per-button synchronise and debounce.
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_debounce_bit (
            .clock (clock),
            .reset (reset),
            .raw   (btn_raw[i]),
            .state (btn_state[i])
        );
    end

    always_comb begin
        button_data = sel_nibble(btn_state, button_sel);
    end

    // Falling-edge detect on the presented nibble. A select change that
    // exposes a pressed button counts as a falling edge too.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_data <= 4'hF;
            joy_irq   <= 1'b0;
        end else begin
            prev_data <= button_data;
            joy_irq   <= |(prev_data & ~button_data);
        end
    end

endmodule

// File: tb/tb_joypad_debouncer.sv
module tb_joypad_debouncer;

    logic       clock;
    logic       reset;
    logic [7:0] btn_raw;
    logic [1:0] button_sel;
    logic [3:0] button_data;
    logic [7:0] btn_state;
    logic       joy_irq;

    int tests_run;
    int tests_failed;
    int irq_cnt;
    int irq_base;

    joypad_debouncer #(
        .DEBOUNCE_CYCLES (16'd4),
        .CNT_WIDTH       (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .button_sel  (button_sel),
        .button_data (button_data),
        .btn_state   (btn_state),
        .joy_irq     (joy_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count irq pulses, sampled mid-cycle.
    always @(negedge clock) begin
        if (joy_irq) irq_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        irq_cnt      = 0;
        reset        = 1'b1;
        btn_raw      = 8'hFF;
        button_sel   = 2'b11;

        // Reset hold
        tick(3);
        check_eq("rst_data",  {28'd0, button_data}, 32'hF);
        check_eq("rst_state", {24'd0, btn_state},   32'h00);
        check_eq("rst_irq",   {31'd0, joy_irq},     32'h0);
        reset = 1'b0;
        tick(5);
        check_eq("rel_state_e5", {24'd0, btn_state}, 32'h00);
        tick(1);
        check_eq("rel_state_e6", {24'd0, btn_state}, 32'hFF);
        check_eq("rel_data_sel11", {28'd0, button_data}, 32'hF);
        btn_raw = 8'h00;
        tick(8);
        check_eq("clear_state", {24'd0, btn_state}, 32'h00);
        check_eq("hold_no_irq", irq_cnt, 0);

        // Clean press of Right with directions selected
        button_sel = 2'b10;
        btn_raw    = 8'h01;
        irq_base   = irq_cnt;
        tick(5);
        check_eq("press_data_e5", {28'd0, button_data}, 32'hF);
        tick(1);
        check_eq("press_data_e6", {28'd0, button_data}, 32'hE);
        check_eq("press_irq_e6",  {31'd0, joy_irq},     32'h0);
        tick(1);
        check_eq("press_irq_e7",  {31'd0, joy_irq},     32'h1);
        tick(1);
        check_eq("press_irq_e8",  {31'd0, joy_irq},     32'h0);
        check_eq("press_irq_cnt", irq_cnt - irq_base, 1);
        btn_raw = 8'h00;
        tick(8);
        check_eq("press_rel_data", {28'd0, button_data}, 32'hF);
        check_eq("press_rel_irq", irq_cnt - irq_base, 1);

        // Bounce on B: 3 high, 1 low, repeated, then low
        button_sel = 2'b01;
        irq_base   = irq_cnt;
        for (int r = 0; r < 4; r++) begin
            btn_raw = 8'h20;
            for (int k = 0; k < 3; k++) begin
                tick(1);
                check_eq("bounce_state", {24'd0, btn_state}, 32'h00);
            end
            btn_raw = 8'h00;
            tick(1);
            check_eq("bounce_state", {24'd0, btn_state}, 32'h00);
        end
        tick(8);
        check_eq("bounce_final_state", {24'd0, btn_state}, 32'h00);
        check_eq("bounce_data", {28'd0, button_data}, 32'hF);
        check_eq("bounce_irq", irq_cnt - irq_base, 0);

        // Select mux with Start + Left held
        button_sel = 2'b11;
        btn_raw    = 8'h82;
        tick(8);
        check_eq("mux_state", {24'd0, btn_state}, 32'h82);
        check_eq("mux_sel11", {28'd0, button_data}, 32'hF);
        irq_base   = irq_cnt;
        button_sel = 2'b10;
        #1;
        check_eq("mux_sel10", {28'd0, button_data}, 32'hD);
        tick(2);
        check_eq("mux_irq_10", irq_cnt - irq_base, 1);
        button_sel = 2'b01;
        #1;
        check_eq("mux_sel01", {28'd0, button_data}, 32'h7);
        tick(2);
        check_eq("mux_irq_01", irq_cnt - irq_base, 2);
        button_sel = 2'b00;
        #1;
        check_eq("mux_sel00", {28'd0, button_data}, 32'h5);
        tick(2);
        check_eq("mux_irq_00", irq_cnt - irq_base, 3);

        // Release of A with actions selected
        button_sel = 2'b01;
        btn_raw    = 8'h10;
        tick(10);
        check_eq("rls_held_state", {24'd0, btn_state}, 32'h10);
        check_eq("rls_held_data", {28'd0, button_data}, 32'hE);
        irq_base = irq_cnt;
        btn_raw  = 8'h00;
        tick(5);
        check_eq("rls_data_e5", {28'd0, button_data}, 32'hE);
        tick(1);
        check_eq("rls_data_e6", {28'd0, button_data}, 32'hF);
        tick(3);
        check_eq("rls_no_irq", irq_cnt - irq_base, 0);

        // Mid-count reset on Down
        button_sel = 2'b10;
        btn_raw    = 8'h08;
        tick(4);
        reset = 1'b1;
        tick(1);
        check_eq("mrst_state", {24'd0, btn_state}, 32'h00);
        check_eq("mrst_irq", {31'd0, joy_irq}, 32'h0);
        reset    = 1'b0;
        irq_base = irq_cnt;
        tick(5);
        check_eq("mrst_state_e5", {24'd0, btn_state}, 32'h00);
        tick(1);
        check_eq("mrst_state_e6", {24'd0, btn_state}, 32'h08);
        check_eq("mrst_data", {28'd0, button_data}, 32'h7);
        tick(2);
        check_eq("mrst_irq_cnt", irq_cnt - irq_base, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
